// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes and debounces a key, times marks and spaces in units,
// and emits ASCII characters with a one-cycle valid strobe plus active-low status LEDs.
module morse_decoder #(
  parameter int unsigned UNIT_CYCLES     = 4_800_000,
  parameter int unsigned DEBOUNCE_CYCLES = 48_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key,
  output logic [7:0] o_char,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b
);

  localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  // cnt clears on the cycle before a level starts, so on a level's last cycle it reads length-1.
  localparam logic [25:0]    DashThr = 26'(2 * UNIT_CYCLES - 1);
  localparam logic [25:0]    WordThr = 26'(5 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StGap} state_e;

  logic           sync1_q, sync2_q, key_db_q;
  logic [DbW-1:0] db_cnt_q;
  logic           flip, rise, fall;
  logic [25:0]    cnt_q;
  state_e         state_q, state_d;
  logic [4:0]     sym_q, sym_d;
  logic [2:0]     len_q, len_d;
  logic           ovf_q, ovf_d;
  logic           emit, emit_err;
  logic [7:0]     emit_char, lut_char;
  logic [7:0]     char_q;
  logic           valid_q, err_q, led_r_q, led_g_q;

  assign flip = (sync2_q != key_db_q) && (db_cnt_q == DbLast);
  assign rise = flip & ~key_db_q;
  assign fall = flip & key_db_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      key_db_q <= 1'b0;
      db_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= i_key;
      sync2_q <= sync1_q;
      if (flip) begin
        key_db_q <= sync2_q;
        db_cnt_q <= '0;
      end else if (sync2_q != key_db_q) begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end else begin
        db_cnt_q <= '0;
      end
      if (flip) cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + 26'd1;
    end
  end

  always_comb begin
    lut_char = 8'h3F;
    case ({len_q, sym_q})
      {3'd1, 5'b00000}: lut_char = "E";
      {3'd1, 5'b00001}: lut_char = "T";
      {3'd2, 5'b00000}: lut_char = "I";
      {3'd2, 5'b00001}: lut_char = "A";
      {3'd2, 5'b00010}: lut_char = "N";
      {3'd2, 5'b00011}: lut_char = "M";
      {3'd3, 5'b00000}: lut_char = "S";
      {3'd3, 5'b00001}: lut_char = "U";
      {3'd3, 5'b00010}: lut_char = "R";
      {3'd3, 5'b00011}: lut_char = "W";
      {3'd3, 5'b00100}: lut_char = "D";
      {3'd3, 5'b00101}: lut_char = "K";
      {3'd3, 5'b00110}: lut_char = "G";
      {3'd3, 5'b00111}: lut_char = "O";
      {3'd4, 5'b00000}: lut_char = "H";
      {3'd4, 5'b00001}: lut_char = "V";
      {3'd4, 5'b00010}: lut_char = "F";
      {3'd4, 5'b00100}: lut_char = "L";
      {3'd4, 5'b00110}: lut_char = "P";
      {3'd4, 5'b00111}: lut_char = "J";
      {3'd4, 5'b01000}: lut_char = "B";
      {3'd4, 5'b01001}: lut_char = "X";
      {3'd4, 5'b01010}: lut_char = "C";
      {3'd4, 5'b01011}: lut_char = "Y";
      {3'd4, 5'b01100}: lut_char = "Z";
      {3'd4, 5'b01101}: lut_char = "Q";
      {3'd5, 5'b11111}: lut_char = "0";
      {3'd5, 5'b01111}: lut_char = "1";
      {3'd5, 5'b00111}: lut_char = "2";
      {3'd5, 5'b00011}: lut_char = "3";
      {3'd5, 5'b00001}: lut_char = "4";
      {3'd5, 5'b00000}: lut_char = "5";
      {3'd5, 5'b10000}: lut_char = "6";
      {3'd5, 5'b11000}: lut_char = "7";
      {3'd5, 5'b11100}: lut_char = "8";
      {3'd5, 5'b11110}: lut_char = "9";
      default:          lut_char = 8'h3F;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    emit      = 1'b0;
    emit_err  = 1'b0;
    emit_char = 8'h00;
    unique case (state_q)
      StIdle: if (rise) state_d = StMark;
      StMark: begin
        if (fall) begin
          if (len_q == 3'd5) begin
            ovf_d = 1'b1;
          end else begin
            sym_d = {sym_q[3:0], (cnt_q >= DashThr)};
            len_d = len_q + 3'd1;
          end
          state_d = StSpace;
        end
      end
      StSpace: begin
        if (cnt_q == DashThr) begin
          emit      = 1'b1;
          emit_err  = ovf_q || (lut_char == 8'h3F);
          emit_char = ovf_q ? 8'h3F : lut_char;
          sym_d     = '0;
          len_d     = '0;
          ovf_d     = 1'b0;
          state_d   = rise ? StMark : StGap;
        end else if (rise) begin
          state_d = StMark;
        end
      end
      StGap: begin
        if (cnt_q == WordThr) begin
          emit      = 1'b1;
          emit_char = 8'h20;
          state_d   = rise ? StMark : StIdle;
        end else if (rise) begin
          state_d = StMark;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      sym_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      led_r_q <= 1'b1;
      led_g_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      valid_q <= emit;
      err_q   <= emit_err;
      led_g_q <= ~key_db_q;
      if (emit) begin
        char_q  <= emit_char;
        led_r_q <= ~emit_err;
      end
    end
  end

  assign o_char  = char_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_led_r = led_r_q;
  assign o_led_g = led_g_q;
  assign o_led_b = (len_q == 3'd0);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed and random key sequences checked against a
// duration-based Morse model that maps dot/dash strings to characters.
module tb_morse_decoder;

  localparam int unsigned Unit = 100;
  localparam int unsigned Deb  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [7:0] o_char;
  logic       o_valid, o_err, o_led_r, o_led_g, o_led_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         dur_q[$];
  logic       prev_valid = 1'b0;

  string codes [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
    "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };
  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  morse_decoder #(
    .UNIT_CYCLES    (Unit),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_key  (key),
    .o_char (o_char),
    .o_valid(o_valid),
    .o_err  (o_err),
    .o_led_r(o_led_r),
    .o_led_g(o_led_g),
    .o_led_b(o_led_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      check("valid one cycle", {31'd0, prev_valid}, 32'd0);
      got_q.push_back({o_err, o_char});
    end
    prev_valid <= o_valid;
  end

  function automatic logic [7:0] lookup(input string s);
    for (int i = 0; i < 36; i++) if (codes[i] == s) return alpha[i];
    return 8'h3F;
  endfunction

  task automatic push_char(input logic [7:0] c);
    exp_q.push_back({(c == 8'h3F), c});
  endtask

  // dur_q alternates mark, space, mark, space ... (counted in clock cycles)
  task automatic play();
    string sym;
    sym = "";
    for (int i = 0; i < dur_q.size(); i++) begin
      if (i % 2 == 0) begin
        if (dur_q[i] >= int'(2 * Unit)) sym = {sym, "-"};
        else sym = {sym, "."};
      end else if (dur_q[i] >= int'(2 * Unit)) begin
        push_char(lookup(sym));
        sym = "";
        if (dur_q[i] >= int'(5 * Unit)) push_char(8'h20);
      end
      key = (i % 2 == 0);
      repeat (dur_q[i]) @(negedge clk);
    end
  endtask

  task automatic compare_out(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s #%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " o_char"}, {24'd0, o_char}, 32'h00);
    check({tag, " o_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, " o_err"}, {31'd0, o_err}, 32'd0);
    check({tag, " o_led_r"}, {31'd0, o_led_r}, 32'd1);
    check({tag, " o_led_g"}, {31'd0, o_led_g}, 32'd1);
    check({tag, " o_led_b"}, {31'd0, o_led_b}, 32'd1);
  endtask

  initial begin
    string s;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // SOS
    dur_q = '{100, 100, 100, 100, 100, 300, 300, 100, 300, 100, 300, 300,
              100, 100, 100, 100, 100, 800};
    play();
    compare_out("sos");

    // Live LED feedback during a short mark
    key = 1'b1;
    repeat (50) @(negedge clk);
    check("led_g pressed", {31'd0, o_led_g}, 32'd0);
    key = 1'b0;
    repeat (20) @(negedge clk);
    check("led_b symbol", {31'd0, o_led_b}, 32'd0);
    check("led_g released", {31'd0, o_led_g}, 32'd1);
    repeat (780) @(negedge clk);
    push_char("E");
    push_char(8'h20);
    compare_out("led step");

    // Dot/dash threshold
    dur_q = '{199, 800};
    play();
    compare_out("mark 199");
    dur_q = '{200, 800};
    play();
    compare_out("mark 200");

    // Over-length symbol, then recovery
    dur_q = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 300};
    play();
    compare_out("overflow");
    check("led_r on error", {31'd0, o_led_r}, 32'd0);
    dur_q = '{300, 800};
    play();
    compare_out("after overflow");
    check("led_r recovered", {31'd0, o_led_r}, 32'd1);

    // Bounce rejection
    for (int g = 0; g < 5; g++) begin
      key = 1'b1;
      repeat (3) @(negedge clk);
      key = 1'b0;
      repeat ($urandom_range(12, 5)) @(negedge clk);
      check("bounce led_g", {31'd0, o_led_g}, 32'd1);
    end
    repeat (20) @(negedge clk);
    check("bounce led_b", {31'd0, o_led_b}, 32'd1);
    compare_out("bounce");

    // Reset mid-character discards the partial symbol
    key = 1'b1;
    repeat (100) @(negedge clk);
    key = 1'b0;
    repeat (100) @(negedge clk);
    key = 1'b1;
    repeat (300) @(negedge clk);
    key = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("mid reset");
    repeat (700) @(negedge clk);
    compare_out("reset discard");
    dur_q = '{100, 300};
    play();
    compare_out("after reset");
    repeat (400) @(negedge clk);
    push_char(8'h20);
    compare_out("after reset space");

    // Digits and space-threshold coincidence
    dur_q = '{300, 100, 300, 100, 300, 100, 300, 100, 300, 300,
              100, 100, 300, 100, 300, 100, 300, 100, 300, 800};
    play();
    compare_out("digits");
    dur_q = '{100, 200, 300, 800};
    play();
    compare_out("press at threshold");
    dur_q = '{100, 199, 300, 800};
    play();
    compare_out("press before threshold");

    // Random keyed characters
    for (int r = 0; r < 2; r++) begin
      dur_q.delete();
      for (int c = 0; c < 8; c++) begin
        s = codes[$urandom_range(35, 0)];
        for (int e = 0; e < s.len(); e++) begin
          if (s[e] == "-") dur_q.push_back(int'($urandom_range(400, 200)));
          else dur_q.push_back(int'($urandom_range(199, 10)));
          if (e == s.len() - 1) dur_q.push_back(int'($urandom_range(650, 200)));
          else dur_q.push_back(int'($urandom_range(199, 10)));
        end
      end
      dur_q[dur_q.size() - 1] = 800;
      play();
      repeat (20) @(negedge clk);
      compare_out($sformatf("random %0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Morse receiver for the workshop boards: samples a raw push-button/key line, debounces it, times mark and space durations against a configurable unit length, and classifies each mark as dot or dash. It assembles elements into a symbol, looks the symbol up, and emits ASCII characters (A–Z, 0–9, word space) with a one-cycle valid strobe. The RGB LEDs (active-low) give live feedback. It is the receive end of the board's SOS blinker: the same timing units, read back from a human-keyed input.

## Interface

- UNIT_CYCLES, 4_800_000: clock cycles per Morse unit (one dot, ~100 ms at 48 MHz).
- DEBOUNCE_CYCLES, 48_000: cycles the synchronized key must hold a level before the debounced level follows it.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_key  in  1  raw asynchronous key; 1 = key down (mark).
- o_char  out  8  ASCII code of the last decoded character.
- o_valid  out  1  one-cycle strobe; o_char/o_err valid only in this cycle.
- o_err  out  1  qualifies o_valid: symbol unknown or over-length, o_char = 0x3F '?'.
- o_led_r  out  1  active-low; low while the last emitted character was an error.
- o_led_g  out  1  active-low echo of debounced key.
- o_led_b  out  1  active-low; low while the symbol buffer is non-empty.

## Operation

- Input path: 2-flop synchronizer, then debouncer.
  - The debounced level `key_db` changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the current level clears the debounce counter.
- Duration counter `cnt`:
  - 26 bits, cleared to 0 on every `key_db` edge, increments every cycle otherwise.
  - Saturates at all-ones and never wraps.
- State machine states: IDLE, MARK, SPACE, GAP.
  - IDLE: symbol empty. A `key_db` rising edge goes to MARK.
  - MARK, on `key_db` falling edge:
    - Element = dash if `cnt >= 2*UNIT_CYCLES`, else dot.
    - Update `sym <= {sym[3:0], elem}` (dot=0, dash=1) and `len <= len+1`.
    - If len is already 5, set the sticky `ovf` instead.
    - Go to SPACE.
  - SPACE:
    - A rising edge with `cnt < 2*UNIT_CYCLES` returns to MARK (intra-character gap).
    - When `cnt == 2*UNIT_CYCLES`, emit the character, clear sym/len/ovf, and go to GAP.
  - GAP:
    - When `cnt == 5*UNIT_CYCLES`, emit 0x20 with o_err=0 and go to IDLE.
    - A rising edge before that goes to MARK with no space emitted.
- Character lookup on (len, sym):
  - Letters: full A–Z ITU table.
  - Digits: 0–9, all five-element codes.
  - Examples: len2 sym 00001 = 'A'; len3 000 = 'S'; len3 111 = 'O'; len1 0 = 'E'; len1 1 = 'T'; len5 11111 = '0'; len5 01111 = '1'.
  - Any unlisted code, or `ovf` set, gives 0x3F with o_err=1.
- Simultaneous events:
  - If a `key_db` rising edge coincides with the SPACE threshold cycle, the character is emitted and the new mark starts a fresh symbol.
  - The same rule applies to the GAP threshold and the space character.
- No output is ever produced from IDLE. A word space follows only an emitted character.
- o_led_r: set low on an error emit, returns high on the next non-error emit (including space).

## Timing

- Reset values:
  - o_char = 0x00, o_valid = 0, o_err = 0.
  - All LEDs = 1 (off).
  - State IDLE, sym/len/ovf = 0, cnt = 0.
  - Synchronizer and `key_db` = 0.
- Reset mid-character discards the partial symbol. No o_valid follows.
- Edge latency: raw key edge to `key_db` edge is 2 + DEBOUNCE_CYCLES cycles (±1).
- Emit latency:
  - o_valid and o_char are registered and go high in the cycle after the threshold compare is true.
  - o_valid is high for exactly one cycle.
  - o_char holds its value until the next emit.
- o_led_g follows `key_db` with one register of delay.

## Test plan

Bench parameters: UNIT_CYCLES=100, DEBOUNCE_CYCLES=4. Marks and gaps below are counted at `key_db`.

1. Key SOS: dot = 100 cycles, dash = 300, intra-character gap 100, inter-character gap 300, final release held 800 -> o_valid pulses with 'S'(0x53), 'O'(0x4F), 'S'(0x53), then 0x20, all with o_err=0.
2. Threshold: a 199-cycle mark + gap -> 'E'(0x45); a 200-cycle mark + gap -> 'T'(0x54).
3. Six 100-cycle dots then a gap -> one o_valid with 0x3F and o_err=1, o_led_r low; then a dash + gap -> 'T', o_led_r high.
4. Bounce: 3-cycle glitches on i_key with no stable level change -> no o_valid, o_led_g stays high, state stays IDLE.
5. Assert i_rst after ".-" with no gap -> no output, all outputs at reset values; then "." + 300-cycle gap -> 'E' only.
6. Digits "-----" then ".----" (300-cycle gaps) -> '0'(0x30) then '1'(0x31). A press landing exactly on cnt = 200 in SPACE -> the character is emitted and the new mark begins a new symbol.
